// File: rtl/shout_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// shout_pkg : state/mode encodings and LFSR constants shared by shout_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
package shout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TGRST   = 3'd1,
    ST_WAIT_VS = 3'd2,
    ST_RUN     = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_ON     = 2'd1,
    MODE_OFF    = 2'd2,
    MODE_ALT    = 2'd3
  } mode_e;

  localparam logic [31:0] C_LFSR_TAPS = 32'h8020_0003;

  // A Galois LFSR locks up at zero, so a zero seed is promoted to one.
  function automatic logic [31:0] lfsr_fix_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? 32'd1 : seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shout_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// shout_ctrl_if : burst command handshake between requester and shout_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
interface shout_ctrl_if;
  import shout_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  mode_e      cmd_mode;
  logic [7:0] cmd_frames;

  modport master (output cmd_valid, output cmd_mode, output cmd_frames, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_mode, input  cmd_frames, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/shout_lfsr.sv
`default_nettype none
// -----------------------------------------------------------------------------
// shout_lfsr : 32-bit Galois noise LFSR with synchronous load and advance
// Rev 1.0
// -----------------------------------------------------------------------------
module shout_lfsr
  import shout_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  wire         pix_clk,
  input  wire         reset,
  input  wire         load_i,
  input  wire         advance_i,
  input  wire  [31:0] seed_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = lfsr_fix_seed(seed_i);
    end else if (advance_i) begin
      state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? C_LFSR_TAPS : 32'd0);
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      state_q <= lfsr_fix_seed(SEED);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/shout_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// shout_ctrl : frame-synchronous noise-burst controller for a timing generator.
// Define SHOUT_CTRL_RESEED_EN to add the seed_valid/seed_data LFSR reseed port.
// Rev 1.0
// -----------------------------------------------------------------------------
module shout_ctrl
  import shout_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED     = 32'h1,
  parameter int unsigned TG_RST_CYCLES = 16,
  parameter int unsigned GAP_FRAMES    = 2
) (
  input  wire         pix_clk,
  input  wire         reset,
  input  wire         vs_in,
  shout_ctrl_if.slave cmd,
  input  wire         abort,
`ifdef SHOUT_CTRL_RESEED_EN
  input  wire         seed_valid,
  input  wire  [31:0] seed_data,
`endif
  output logic        tg_reset,
  output logic        rnd,
  output logic        burst_active,
  output logic [7:0]  frames_done,
  output logic        done_pulse
);

  localparam logic [7:0] C_TG_LOAD  = 8'(TG_RST_CYCLES - 1);
  localparam logic [7:0] C_GAP_LOAD = 8'(GAP_FRAMES);

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  frames_q, frames_d;
  logic        vs_q, tg_reset_q, rnd_q, rnd_d, active_q, done_q;
  logic        vs_rise, accept, lfsr_load;
  logic [31:0] lfsr_seed, lfsr_state;
  logic        lfsr_hi_unused;

  assign vs_rise       = vs_in & ~vs_q;
  assign cmd.cmd_ready = (state_q == ST_IDLE) & ~abort & ~reset;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

`ifdef SHOUT_CTRL_RESEED_EN
  assign lfsr_load = seed_valid;
  assign lfsr_seed = seed_data;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = 32'd0;
`endif

  shout_lfsr #(
    .SEED      (LFSR_SEED)
  ) u_lfsr (
    .pix_clk   (pix_clk),
    .reset     (reset),
    .load_i    (lfsr_load),
    .advance_i (1'b1),
    .seed_i    (lfsr_seed),
    .state_o   (lfsr_state)
  );

  assign lfsr_hi_unused = |lfsr_state[31:1];

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_TGRST;
          mode_d   = cmd.cmd_mode;
          len_d    = cmd.cmd_frames;
          frames_d = 8'd0;
          cnt_d    = C_TG_LOAD;
        end
      end
      ST_TGRST: begin
        if (abort)                 state_d = ST_IDLE;
        else if (cnt_q == 8'd0)    state_d = ST_WAIT_VS;
        else                       cnt_d   = cnt_q - 8'd1;
      end
      ST_WAIT_VS: begin
        if (abort)                 state_d = ST_IDLE;
        else if (vs_rise)          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_GAP;
          cnt_d   = C_GAP_LOAD;
        end else if (vs_rise) begin
          if (frames_q != 8'hFF) frames_d = frames_q + 8'd1;
          // A length of zero means continuous, so it never terminates the burst.
          if ((len_q != 8'd0) && (frames_q + 8'd1 == len_q)) begin
            state_d = ST_GAP;
            cnt_d   = C_GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if ((cnt_q == 8'd0) || (vs_rise && (cnt_q == 8'd1))) state_d = ST_IDLE;
        else if (vs_rise)                                    cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rnd_d = 1'b0;
    if (state_d == ST_RUN) begin
      case (mode_q)
        MODE_RANDOM: rnd_d = lfsr_state[0];
        MODE_ON:     rnd_d = 1'b1;
        MODE_OFF:    rnd_d = 1'b0;
        MODE_ALT:    rnd_d = ~frames_d[0];
        default:     rnd_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_RANDOM;
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      frames_q   <= 8'd0;
      vs_q       <= 1'b0;
      tg_reset_q <= 1'b1;
      rnd_q      <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      frames_q   <= frames_d;
      vs_q       <= vs_in;
      tg_reset_q <= (state_d == ST_TGRST);
      rnd_q      <= rnd_d;
      active_q   <= (state_d == ST_RUN);
      done_q     <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end
  end

  assign tg_reset     = tg_reset_q;
  assign rnd          = rnd_q;
  assign burst_active = active_q;
  assign frames_done  = frames_q;
  assign done_pulse   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shout_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_shout_ctrl : self-checking bench for shout_ctrl (table, random, corners)
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_shout_ctrl;
  import shout_pkg::*;

  localparam int TG  = 16;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vs_in = 1'b0;
  logic       abort = 1'b0;
  logic       tg_reset, rnd, burst_active, done_pulse;
  logic [7:0] frames_done;
`ifdef SHOUT_CTRL_RESEED_EN
  logic        seed_valid = 1'b0;
  logic [31:0] seed_data  = 32'd0;
`endif

  shout_ctrl_if cmd();

  shout_ctrl #(
    .LFSR_SEED     (32'h1),
    .TG_RST_CYCLES (TG),
    .GAP_FRAMES    (GAP)
  ) dut (
    .pix_clk      (clk),
    .reset        (reset),
    .vs_in        (vs_in),
    .cmd          (cmd),
    .abort        (abort),
`ifdef SHOUT_CTRL_RESEED_EN
    .seed_valid   (seed_valid),
    .seed_data    (seed_data),
`endif
    .tg_reset     (tg_reset),
    .rnd          (rnd),
    .burst_active (burst_active),
    .frames_done  (frames_done),
    .done_pulse   (done_pulse)
  );

  always #5 clk = ~clk;

  // Reference noise source: the Galois recurrence, stepped once per clock edge.
  logic [31:0] lfsr_m = 32'h1, lfsr_prev = 32'h1;
  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    if (reset) lfsr_m <= 32'h1;
`ifdef SHOUT_CTRL_RESEED_EN
    else if (seed_valid) lfsr_m <= (seed_data == 32'd0) ? 32'h1 : seed_data;
`endif
    else lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 32'h8020_0003 : 32'h0);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int rnd_err = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] frames;
    int         exp_run;
    int         exp_fd;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done_pulse === 1'b1) done_cnt++;
  endtask

  function automatic logic exp_rnd(input logic [1:0] mode, input int k, input logic lbit);
    case (mode)
      2'd0:    return lbit;
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return (k % 2) == 0;
    endcase
  endfunction

  // k is the index of the frame in progress within the burst.
  task automatic chk_out(input logic [1:0] mode, input bit run, input int k);
    logic e;
    e = run ? exp_rnd(mode, k, lfsr_prev[0]) : 1'b0;
    if (rnd !== e || burst_active !== run) rnd_err++;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [7:0] frames);
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_mode   = mode_e'(mode);
    cmd.cmd_frames = frames;
    check("cmd_ready_idle", {31'd0, cmd.cmd_ready}, 32'd1);
    tick();
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic wait_tg(output int n);
    n = 0;
    while (tg_reset === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic run_burst(input logic [1:0] mode, input logic [7:0] frames,
                           output int tg_cyc, output int run_ed, output int fd,
                           output int gap_ed, output int dn);
    int phase, k, d0;
    d0 = done_cnt;
    rnd_err = 0;
    issue(mode, frames);
    wait_tg(tg_cyc);
    repeat (2) begin chk_out(mode, 1'b0, 0); tick(); end
    phase = 0; k = 0; run_ed = 0; gap_ed = 0; fd = -1;
    for (int f = 0; f < int'(frames) + GAP + 4 && done_cnt == d0; f++) begin
      vs_in = 1'b1;
      tick();
      vs_in = 1'b0;
      if (phase == 0) phase = 1;
      else if (phase == 1) begin
        run_ed++;
        if (burst_active !== 1'b1) begin phase = 2; fd = int'(frames_done); end
        else k++;
      end else gap_ed++;
      repeat ($urandom_range(2, 5)) begin chk_out(mode, phase == 1, k); tick(); end
    end
    dn = done_cnt - d0;
  endtask

  initial begin
    int tg_c, run_e, fd, gap_e, dn, n, d0;
    logic [1:0] m;
    logic [7:0] fr;

    vecs[0] = '{2'd0, 8'd3, 3, 3};
    vecs[1] = '{2'd3, 8'd4, 4, 4};
    vecs[2] = '{2'd1, 8'd1, 1, 1};
    vecs[3] = '{2'd2, 8'd2, 2, 2};
    vecs[4] = '{2'd3, 8'd5, 5, 5};

    cmd.cmd_valid  = 1'b0;
    cmd.cmd_mode   = MODE_RANDOM;
    cmd.cmd_frames = 8'd0;

    repeat (3) tick();
    check("rst_tg_reset",     {31'd0, tg_reset},      32'd1);
    check("rst_rnd",          {31'd0, rnd},           32'd0);
    check("rst_burst_active", {31'd0, burst_active},  32'd0);
    check("rst_frames_done",  {24'd0, frames_done},   32'd0);
    check("rst_done_pulse",   {31'd0, done_pulse},    32'd0);
    check("rst_cmd_ready",    {31'd0, cmd.cmd_ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_cmd_ready", {31'd0, cmd.cmd_ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].mode, vecs[i].frames, tg_c, run_e, fd, gap_e, dn);
      check("vec_tg_cycles",  tg_c,    TG);
      check("vec_run_edges",  run_e,   vecs[i].exp_run);
      check("vec_frames_done", fd,     vecs[i].exp_fd);
      check("vec_gap_edges",  gap_e,   GAP);
      check("vec_done_pulses", dn,     1);
      check("vec_rnd_stream", rnd_err, 0);
    end

    repeat (6) begin
      m  = 2'($urandom_range(0, 3));
      fr = 8'($urandom_range(1, 7));
      run_burst(m, fr, tg_c, run_e, fd, gap_e, dn);
      check("rand_run_edges",   run_e,   int'(fr));
      check("rand_frames_done", fd,      int'(fr));
      check("rand_done_pulses", dn,      1);
      check("rand_rnd_stream",  rnd_err, 0);
    end

    // Continuous random burst: saturation plus long noise comparison.
    rnd_err = 0;
    issue(2'd0, 8'd0);
    wait_tg(tg_c);
    tick();
    for (int p = 0; p < 300; p++) begin
      vs_in = 1'b1;
      tick();
      vs_in = 1'b0;
`ifdef SHOUT_CTRL_RESEED_EN
      if (p == 100) begin seed_valid = 1'b1; seed_data = 32'd0; end
`endif
      repeat (3) begin
        chk_out(2'd0, 1'b1, 0);
        tick();
`ifdef SHOUT_CTRL_RESEED_EN
        seed_valid = 1'b0;
`endif
      end
    end
    check("sat_frames_done", {24'd0, frames_done}, 32'd255);
    check("sat_lfsr_stream", rnd_err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_inactive", {31'd0, burst_active}, 32'd0);
    check("abort_run_rnd",      {31'd0, rnd},          32'd0);
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 6) begin
      vs_in = 1'b1; tick(); vs_in = 1'b0; tick(); tick();
      n++;
    end
    check("abort_gap_edges", n, GAP);

    // Abort during the fifth timing-generator reset cycle.
    issue(2'd1, 8'd3);
    repeat (4) tick();
    check("tgrst_cycle5_tg_reset", {31'd0, tg_reset}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    check("abort_tgrst_tg_reset",  {31'd0, tg_reset},      32'd0);
    check("abort_tgrst_done",      {31'd0, done_pulse},    32'd1);
    check("abort_tgrst_cmd_ready", {31'd0, cmd.cmd_ready}, 32'd1);
    tick();
    check("abort_tgrst_done_1cyc", {31'd0, done_pulse},    32'd0);

    // Abort and a command together in IDLE: the command must be refused.
    abort = 1'b1;
    cmd.cmd_valid = 1'b1;
    #1;
    check("abort_wins_ready", {31'd0, cmd.cmd_ready}, 32'd0);
    tick();
    cmd.cmd_valid = 1'b0;
    abort = 1'b0;
    repeat (2) tick();
    check("abort_wins_no_tgrst", {31'd0, tg_reset}, 32'd0);

    // Reset in the middle of a burst.
    issue(2'd1, 8'd0);
    wait_tg(tg_c);
    vs_in = 1'b1; tick(); vs_in = 1'b0;
    vs_in = 1'b0; tick();
    vs_in = 1'b1; tick(); vs_in = 1'b0; tick();
    check("mid_run_active", {31'd0, burst_active}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_active",   {31'd0, burst_active}, 32'd0);
    check("mid_rst_tg_reset", {31'd0, tg_reset},     32'd1);
    check("mid_rst_frames",   {24'd0, frames_done},  32'd0);
    check("mid_rst_rnd",      {31'd0, rnd},          32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shout_ctrl.md
SHOUT_CTRL -- requirements
Module: shout_ctrl

Interface
REQ-001 SHALL have parameter LFSR_SEED, 32'h1, nonzero reset seed of the noise LFSR.
REQ-002 SHALL have parameter TG_RST_CYCLES, 16, cycles of timing-generator reset before each burst (range 1..255).
REQ-003 SHALL have parameter GAP_FRAMES, 2, blank frames after each burst (range 0..15).
REQ-004 SHALL have one clock and a synchronous active-high reset, named as follows: pix_clk  in  1  pixel clock, all logic on rising edge.
REQ-005 SHALL have: reset  in  1  synchronous, active-high.
REQ-006 SHALL have: vs_in  in  1  vsync from timing generator, active-high.
REQ-007 SHALL have: cmd_valid  in  1  burst request; cmd_ready  out  1  accept qualifier.
REQ-008 SHALL have: cmd_mode  in  2  0=random, 1=all-on, 2=all-off, 3=alternate per frame.
REQ-009 SHALL have: cmd_frames  in  8  burst length in frames, 0=continuous.
REQ-010 SHALL have: abort  in  1  terminate current operation.
REQ-011 SHALL have: tg_reset  out  1  drives timing generator reset; rnd  out  1  noise bit to timing generator.
REQ-012 SHALL have: burst_active  out  1; frames_done  out  8; done_pulse  out  1.

Function
REQ-013 SHALL implement states IDLE, TGRST, WAIT_VS, RUN, GAP.
REQ-014 cmd_ready SHALL be high only in IDLE with abort low; command accepted when cmd_valid & cmd_ready, latching mode/frames, clearing frames_done, entering TGRST next cycle.
REQ-015 TGRST SHALL hold tg_reset high exactly TG_RST_CYCLES cycles, then enter WAIT_VS.
REQ-016 vs rising edge SHALL be detected as vs_in & ~vs_q (vs_q registered vs_in), one-cycle latency.
REQ-017 WAIT_VS SHALL enter RUN on first vs rising edge; burst_active high in RUN only.
REQ-018 RUN SHALL increment frames_done on each vs rising edge, saturating at 255.
REQ-019 RUN SHALL enter GAP on the vs edge where frames_done+1 == cmd_frames; with cmd_frames=0 only abort exits RUN.
REQ-020 GAP SHALL count GAP_FRAMES vs rising edges (0 = immediate), then enter IDLE with done_pulse high one cycle.
REQ-021 rnd SHALL be registered: mode0 lfsr[0], mode1 1, mode2 0, mode3 ~frames_done[0]; rnd=0 outside RUN.
REQ-022 LFSR SHALL be 32-bit Galois, taps 32'h80200003, advancing every cycle in every state.
REQ-023 abort in RUN SHALL enter GAP next cycle; in TGRST or WAIT_VS SHALL enter IDLE next cycle, tg_reset low, done_pulse high one cycle; in IDLE/GAP ignored.
REQ-024 abort and cmd_valid in the same IDLE cycle: abort wins, command not accepted.

Reset
REQ-025 On reset: state IDLE, LFSR=LFSR_SEED (1 if LFSR_SEED=0), tg_reset=1, rnd=0, burst_active=0, frames_done=0, done_pulse=0, vs_q=0; cmd_ready=0 during reset, 1 the cycle after.
REQ-026 Reset mid-burst SHALL take effect the next edge regardless of state.

Configuration
REQ-027 With SHOUT_CTRL_RESEED_EN defined, ports seed_valid (in 1) and seed_data (in 32) SHALL exist; seed_valid loads seed_data (0 replaced by 1) into the LFSR next cycle, overriding advance; without it ports are absent and LFSR seeds only at reset.

Structure
REQ-028 Package shout_pkg SHALL hold mode encodings, state enum, LFSR tap constant.
REQ-029 LFSR SHALL be sub-module shout_lfsr (seed, load, advance, 32-bit state out).

Verification
REQ-030 Reset, cmd mode0 frames=3: tg_reset high 16 cycles, 3 vs edges in RUN, frames_done=3, GAP 2 frames, done_pulse once.
REQ-031 mode3 frames=4: rnd per frame = 1,0,1,0; rnd=0 in GAP/IDLE.
REQ-032 frames=0 run 300 frames: frames_done saturates 255; abort -> GAP next cycle.
REQ-033 abort during TGRST cycle 5: IDLE next cycle, tg_reset low, done_pulse 1 cycle; abort+cmd_valid in IDLE: not accepted.
REQ-034 mode0 from seed 1: rnd matches reference LFSR model for 1000 cycles; reseed (macro on) seed_data=0 loads 1.
